ltc2500_acq_ctrl: RTL and testbench

//   Sequences one LTC2500-style serial ADC: issues the convert pulse, waits for busy to

---
 rtl/ltc2500_acq_ctrl_pkg.sv | 21 ++
 rtl/ltc2500_acq_ctrl_if.sv | 24 ++
 rtl/ltc2500_acq_ctrl_sync_2ff.sv | 22 ++
 rtl/ltc2500_acq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ltc2500_acq_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ltc2500_acq_ctrl_pkg.sv
// Shared types and helpers for the LTC2500 acquisition controller.
package ltc2500_acq_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ABORT   = 3'd6
  } state_e;

  // Bits needed to hold every value 0..max_val (never less than one).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ltc2500_acq_ctrl_if.sv
// Request/result and ADC pin bundle; slave is the controller's view, master the surroundings.
interface ltc2500_acq_ctrl_if #(
  parameter int DATA_WIDTH = 20
);
  logic                  start;
  logic                  ready;
  logic                  adc_convert;
  logic                  adc_busy;
  logic                  adc_sck;
  logic                  adc_sdo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  timeout_err;

  modport master (
    output start, adc_busy, adc_sdo,
    input  ready, adc_convert, adc_sck, data_out, data_valid, timeout_err
  );

  modport slave (
    input  start, adc_busy, adc_sdo,
    output ready, adc_convert, adc_sck, data_out, data_valid, timeout_err
  );
endinterface

// File: rtl/ltc2500_acq_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous adc_busy pin, cleared by reset.
module ltc2500_acq_ctrl_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ltc2500_acq_ctrl.sv
// Convert / busy-wait / serial-readout sequencer for one LTC2500-style ADC.
// state    | meaning
// IDLE     | waiting for start or a queued request
// CONV     | adc_convert high for CONV_CYCLES
// WAIT_HI  | waiting for synced busy to rise
// WAIT_LO  | waiting for synced busy to fall
// SHIFT    | clocking DATA_WIDTH bits in on adc_sck
// DONE     | publish sample, one-cycle data_valid
// ABORT    | busy wait expired, one-cycle timeout_err
module ltc2500_acq_ctrl
  import ltc2500_acq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CONV_CYCLES  = 3,
  parameter int SCK_HALF     = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  ltc2500_acq_ctrl_if.slave bus
);
  localparam int TMR_MAX = (CONV_CYCLES > SCK_HALF) ? CONV_CYCLES : SCK_HALF;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int BUSY_W  = cnt_w(BUSY_TIMEOUT);
  localparam int BIT_W   = cnt_w(DATA_WIDTH);

  localparam logic [TMR_W-1:0]  CONV_LD = TMR_W'(CONV_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SCK_LD  = TMR_W'(SCK_HALF - 1);
  localparam logic [BUSY_W-1:0] BUSY_TC = BUSY_W'(BUSY_TIMEOUT);
  localparam logic [BIT_W-1:0]  BIT_TC  = BIT_W'(DATA_WIDTH);

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [BUSY_W-1:0]       busy_cnt_q, busy_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sck_q, sck_d;
  logic                    pending_q, pending_d;
  logic                    conv_q, conv_d;
  logic                    valid_q, valid_d;
  logic                    tmo_q, tmo_d;
  logic                    ready_q, ready_d;
  logic                    busy_s;

  ltc2500_acq_ctrl_sync_2ff u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.adc_busy),
    .q_o   (busy_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      busy_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      sck_q      <= 1'b0;
      pending_q  <= 1'b0;
      conv_q     <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      busy_cnt_q <= busy_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      sck_q      <= sck_d;
      pending_q  <= pending_d;
      conv_q     <= conv_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    busy_cnt_d = busy_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    sck_d      = sck_q;
    pending_d  = pending_q;
    if (state_q != ST_IDLE && bus.start) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.start || pending_q) begin
          state_d   = ST_CONV;
          pending_d = 1'b0;
          tmr_d     = CONV_LD;
        end
      end
      ST_CONV: begin
        if (tmr_q == '0) begin
          state_d    = ST_WAIT_HI;
          busy_cnt_d = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WAIT_HI: begin
        if (busy_s) begin
          state_d    = ST_WAIT_LO;
          busy_cnt_d = '0;
        end else if (busy_cnt_q == BUSY_TC) begin
          state_d = ST_ABORT;
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!busy_s) begin
          state_d   = ST_SHIFT;
          tmr_d     = SCK_LD;
          bit_cnt_d = '0;
          sck_d     = 1'b0;
        end else if (busy_cnt_q == BUSY_TC) begin
          state_d = ST_ABORT;
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_W'(1);
        end
      end
      ST_SHIFT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          tmr_d = SCK_LD;
          // The sample is taken on the same cycle sck is driven high.
          if (!sck_q) begin
            sck_d     = 1'b1;
            sr_d      = {sr_q[DATA_WIDTH-2:0], bus.adc_sdo};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == BIT_TC) state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    conv_d  = (state_d == ST_CONV);
    valid_d = (state_d == ST_DONE);
    tmo_d   = (state_d == ST_ABORT);
    ready_d = (state_d == ST_IDLE) && !pending_d;
    data_d  = valid_d ? sr_q : data_q;
  end

  assign bus.ready       = ready_q;
  assign bus.adc_convert = conv_q;
  assign bus.adc_sck     = sck_q;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_ltc2500_acq_ctrl.sv
// Bench for ltc2500_acq_ctrl: behavioural ADC models drive two instances (20-bit and 16-bit).
module tb_ltc2500_acq_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ltc2500_acq_ctrl_if #(.DATA_WIDTH(20)) bus0 ();
  ltc2500_acq_ctrl_if #(.DATA_WIDTH(16)) bus1 ();

  logic start0 = 1'b0, busy0 = 1'b0;
  logic start1 = 1'b0, busy1 = 1'b0;
  logic sdo0, sdo1;
  assign bus0.start    = start0;
  assign bus0.adc_busy = busy0;
  assign bus0.adc_sdo  = sdo0;
  assign bus1.start    = start1;
  assign bus1.adc_busy = busy1;
  assign bus1.adc_sdo  = sdo1;

  ltc2500_acq_ctrl #(.DATA_WIDTH(20), .CONV_CYCLES(3), .SCK_HALF(2), .BUSY_TIMEOUT(1024))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ltc2500_acq_ctrl #(.DATA_WIDTH(16), .CONV_CYCLES(3), .SCK_HALF(1), .BUSY_TIMEOUT(1024))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: busy pulse after each convert edge, MSB presented at busy fall,
  // next bit after every sck falling edge. mode 0 normal, 1 never busy, 2 busy stuck.
  logic [19:0] smp0_q[$], exp0_q[$];
  logic [19:0] adc0_smp = '0, last0 = '0;
  int adc0_mode = 0, fall0 = 0, base0 = 0, idx0;
  always @(negedge bus0.adc_sck) fall0++;
  assign idx0 = 19 - (fall0 - base0);
  assign sdo0 = (idx0 >= 0 && idx0 <= 19) ? adc0_smp[idx0[4:0]] : 1'b0;

  always @(posedge bus0.adc_convert) begin
    if (adc0_mode == 0) begin
      adc0_smp = (smp0_q.size() != 0) ? smp0_q.pop_front() : 20'($urandom);
      exp0_q.push_back(adc0_smp);
      repeat ($urandom_range(3, 1)) @(negedge clk);
      busy0 = 1'b1;
      repeat ($urandom_range(30, 6)) @(negedge clk);
      base0 = fall0;
      busy0 = 1'b0;
    end else if (adc0_mode == 2) begin
      repeat (2) @(negedge clk);
      busy0 = 1'b1;
      wait (adc0_mode != 2);
      busy0 = 1'b0;
    end
  end

  logic [15:0] smp1_q[$], exp1_q[$];
  logic [15:0] adc1_smp = '0, last1 = '0;
  int fall1 = 0, base1 = 0, idx1;
  always @(negedge bus1.adc_sck) fall1++;
  assign idx1 = 15 - (fall1 - base1);
  assign sdo1 = (idx1 >= 0 && idx1 <= 15) ? adc1_smp[idx1[3:0]] : 1'b0;

  always @(posedge bus1.adc_convert) begin
    adc1_smp = (smp1_q.size() != 0) ? smp1_q.pop_front() : 16'($urandom);
    exp1_q.push_back(adc1_smp);
    repeat ($urandom_range(3, 1)) @(negedge clk);
    busy1 = 1'b1;
    repeat ($urandom_range(30, 6)) @(negedge clk);
    base1 = fall1;
    busy1 = 1'b0;
  end

  // Monitors: per-conversion sck/convert counts and the sample scoreboard.
  int vld0_n = 0, sck0_cnt = 0, conv0_len = 0, tmo0_n = 0, sckr0_tot = 0;
  int vld1_n = 0, sck1_cnt = 0, conv1_len = 0;
  logic sck0_p = 1'b0, conv0_p = 1'b0, sck1_p = 1'b0, conv1_p = 1'b0;

  always @(negedge clk) begin
    if (bus0.adc_convert && !conv0_p) begin conv0_len = 0; sck0_cnt = 0; end
    if (bus0.adc_convert) conv0_len++;
    if (bus0.adc_sck && !sck0_p) begin sck0_cnt++; sckr0_tot++; end
    if (bus0.timeout_err) tmo0_n++;
    if (bus0.data_valid) begin
      vld0_n++;
      chk_eq("d0_exp_avail", 32'(exp0_q.size() != 0), 32'd1);
      if (exp0_q.size() != 0) last0 = exp0_q.pop_front();
      chk_eq("d0_data", 32'(bus0.data_out), 32'(last0));
      chk_eq("d0_sck_rises", sck0_cnt, 20);
      chk_eq("d0_conv_len", conv0_len, 3);
    end
    conv0_p = bus0.adc_convert;
    sck0_p  = bus0.adc_sck;
  end

  always @(negedge clk) begin
    if (bus1.adc_convert && !conv1_p) begin conv1_len = 0; sck1_cnt = 0; end
    if (bus1.adc_convert) conv1_len++;
    if (bus1.adc_sck && !sck1_p) sck1_cnt++;
    if (bus1.data_valid) begin
      vld1_n++;
      chk_eq("d1_exp_avail", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) last1 = exp1_q.pop_front();
      chk_eq("d1_data", 32'(bus1.data_out), 32'(last1));
      chk_eq("d1_sck_rises", sck1_cnt, 16);
      chk_eq("d1_conv_len", conv1_len, 3);
    end
    conv1_p = bus1.adc_convert;
    sck1_p  = bus1.adc_sck;
  end

  task automatic pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_vld0(input int target, input string tag);
    int k = 0;
    while (vld0_n < target && k < 5000) begin @(negedge clk); k++; end
    chk_eq(tag, vld0_n, target);
  endtask

  task automatic wait_vld1(input int target, input string tag);
    int k = 0;
    while (vld1_n < target && k < 5000) begin @(negedge clk); k++; end
    chk_eq(tag, vld1_n, target);
  endtask

  task automatic wait_sck0(input int target, input string tag);
    int k = 0;
    while (sck0_cnt != target && k < 5000) begin @(negedge clk); k++; end
    chk_eq(tag, sck0_cnt, target);
  endtask

  initial begin
    int base_v, base_t, base_s, k;
    repeat (3) @(negedge clk);
    chk_eq("rst_ready", bus0.ready, 1);
    chk_eq("rst_convert", bus0.adc_convert, 0);
    chk_eq("rst_sck", bus0.adc_sck, 0);
    chk_eq("rst_data", bus0.data_out, 0);
    chk_eq("rst_valid", bus0.data_valid, 0);
    chk_eq("rst_tmo", bus0.timeout_err, 0);
    chk_eq("rst_ready1", bus1.ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single conversion
    smp0_q.push_back(20'hA5A5C);
    pulse0();
    wait_vld0(1, "t1_valid");
    repeat (10) @(negedge clk);
    chk_eq("t1_hold", bus0.data_out, 20'hA5A5C);
    chk_eq("t1_ready", bus0.ready, 1);

    // back-to-back requests queued during SHIFT, extra starts dropped
    base_v = vld0_n;
    smp0_q.push_back(20'h00000); smp0_q.push_back(20'h00001);
    smp0_q.push_back(20'h00002); smp0_q.push_back(20'h00003);
    smp0_q.push_back(20'hFFFFF);
    pulse0();
    for (int i = 0; i < 4; i++) begin
      wait_sck0(5, "t2_mid_shift");
      pulse0();
      @(negedge clk);
      pulse0();
      wait_vld0(base_v + i + 1, "t2_valid");
    end
    wait_vld0(base_v + 5, "t2_last_valid");
    repeat (300) @(negedge clk);
    chk_eq("t2_count", vld0_n, base_v + 5);
    chk_eq("t2_ready", bus0.ready, 1);

    // randomized samples, busy lengths and request spacing
    base_v = vld0_n;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(6, 0)) @(negedge clk);
      pulse0();
      wait_vld0(base_v + i + 1, "rand_valid");
    end

    // busy never rises
    adc0_mode = 1;
    base_v = vld0_n;
    start0 = 1'b1;
    for (k = 1; k <= 1200; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (bus0.timeout_err) break;
    end
    chk_eq("t3_tmo_cycle", k, 1029);
    @(negedge clk);
    chk_eq("t3_tmo_strobe", bus0.timeout_err, 0);
    chk_eq("t3_ready", bus0.ready, 1);
    chk_eq("t3_no_valid", vld0_n, base_v);
    chk_eq("t3_hold", bus0.data_out, 32'(last0));
    adc0_mode = 0;

    // busy stuck high
    adc0_mode = 2;
    base_v = vld0_n; base_t = tmo0_n; base_s = sckr0_tot;
    start0 = 1'b1;
    for (k = 1; k <= 1500; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (bus0.timeout_err) break;
    end
    chk_eq("t4_tmo_window", 32'(k >= 1028 && k <= 1034), 1);
    @(negedge clk);
    adc0_mode = 0;
    repeat (5) @(negedge clk);
    chk_eq("t4_tmo_count", tmo0_n, base_t + 1);
    chk_eq("t4_no_sck", sckr0_tot, base_s);
    chk_eq("t4_no_valid", vld0_n, base_v);
    chk_eq("t4_ready", bus0.ready, 1);

    // reset in the middle of readout
    smp0_q.push_back(20'h6B3D1);
    pulse0();
    wait_sck0(10, "t5_bit10");
    base_v = vld0_n;
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("t5_sck_low", bus0.adc_sck, 0);
    chk_eq("t5_conv_low", bus0.adc_convert, 0);
    chk_eq("t5_no_valid", bus0.data_valid, 0);
    chk_eq("t5_data_clr", bus0.data_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp0_q.delete();
    repeat (40) @(negedge clk);
    chk_eq("t5_still_no_valid", vld0_n, base_v);
    smp0_q.push_back(20'h12345);
    pulse0();
    wait_vld0(base_v + 1, "t5_valid");
    @(negedge clk);
    chk_eq("t5_data", bus0.data_out, 20'h12345);

    // 16-bit instance with the fastest sck
    smp1_q.push_back(16'hBEEF);
    pulse1();
    wait_vld1(1, "t6_valid");
    @(negedge clk);
    chk_eq("t6_data", bus1.data_out, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(4, 0)) @(negedge clk);
      pulse1();
      wait_vld1(i + 2, "t6_rand_valid");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
